// File: rtl/frame_writer_pkg.sv
`default_nettype none
// =============================================================================
// Module   : frame_writer_pkg
// Brief    : Shared frame geometry, pixel/address sizes and writer state codes,
//            common to the frame writer and the VGA read side.
// Revision : 1.0
// =============================================================================
package frame_writer_pkg;

   localparam int IMAGE_WIDTH  = 160;
   localparam int IMAGE_HEIGHT = 140;
   localparam int DATA_SIZE    = 11;
   localparam int ADDRESS_SIZE = 14;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2,
      ST_RESYNC = 2'd3
   } state_t;

endpackage : frame_writer_pkg
`default_nettype wire

// File: rtl/frame_writer_pixel_counter.sv
`default_nettype none
// =============================================================================
// Module   : pixel_counter
// Brief    : Raster x/y position and linear frame-buffer address tracker.
// Revision : 1.0
// =============================================================================
module pixel_counter #(
   parameter int X_W = 8,
   parameter int Y_W = 8,
   parameter int A_W = 15
) (
   input  logic           clk_in,
   input  logic           reset_n,
   input  logic           step,
   input  logic           restart,
   input  logic           eol_step,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic [A_W-1:0] addr
);

   localparam logic [X_W-1:0] c_x_one = X_W'(1);
   localparam logic [Y_W-1:0] c_y_one = Y_W'(1);
   localparam logic [A_W-1:0] c_a_one = A_W'(1);

   logic [X_W-1:0] w_base_x;
   logic [Y_W-1:0] w_base_y;
   logic [A_W-1:0] w_base_addr;

   // A restart pixel sits at the frame origin; a step then advances past it.
   assign w_base_x    = restart ? '0 : x;
   assign w_base_y    = restart ? '0 : y;
   assign w_base_addr = restart ? '0 : addr;

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         x    <= '0;
         y    <= '0;
         addr <= '0;
      end else if (step) begin
         x    <= eol_step ? '0 : w_base_x + c_x_one;
         y    <= eol_step ? w_base_y + c_y_one : w_base_y;
         addr <= w_base_addr + c_a_one;
      end else if (restart) begin
         x    <= '0;
         y    <= '0;
         addr <= '0;
      end
   end

endmodule : pixel_counter
`default_nettype wire

// File: rtl/frame_writer.sv
`default_nettype none
// =============================================================================
// Module   : frame_writer
// Brief    : Writes a framed pixel stream into a double-buffered frame store.
// Revision : 1.0
// =============================================================================
module frame_writer
   import frame_writer_pkg::*;
#(
   parameter int image_width  = IMAGE_WIDTH,
   parameter int image_height = IMAGE_HEIGHT,
   parameter int data_size    = DATA_SIZE,
   parameter int address_size = ADDRESS_SIZE
) (
   input  logic                  clk_in,
   input  logic                  reset_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [data_size:0]    s_data,
   input  logic                  s_sof,
   input  logic                  s_eol,
   output logic                  wr_en,
   output logic [address_size:0] wr_address,
   output logic [data_size:0]    wr_data,
   output logic                  wr_bank,
   output logic                  disp_bank,
   output logic                  frame_done,
   output logic                  frame_error,
   output logic [7:0]            frame_count
);

   localparam int c_x_w = $clog2(image_width + 1);
   localparam int c_y_w = $clog2(image_height + 1);
   localparam int c_a_w = address_size + 1;
   localparam logic [c_x_w-1:0] c_x_last = c_x_w'(image_width - 1);
   localparam logic [c_y_w-1:0] c_y_last = c_y_w'(image_height - 1);

   generate
      if (image_width * image_height > 2 ** (address_size + 1)) begin : g_size_check
         $error("frame_writer: image_width*image_height exceeds the address space");
      end
   endgenerate

   state_t             r_state;
   state_t             w_next;
   logic               w_accept;
   logic               w_restart;
   logic               w_take;
   logic               w_write;
   logic               w_err;
   logic [c_x_w-1:0]   w_x;
   logic [c_y_w-1:0]   w_y;
   logic [c_a_w-1:0]   w_addr;
   logic [c_x_w-1:0]   w_cur_x;
   logic [c_y_w-1:0]   w_cur_y;
   logic [c_a_w-1:0]   w_cur_addr;

   assign w_accept  = s_valid & s_ready;
   // A start-of-frame pixel is honoured in every accepting state.
   assign w_restart = w_accept & s_sof;
   assign w_take    = w_accept & (s_sof | (r_state == ST_ACTIVE));

   assign w_cur_x    = w_restart ? '0 : w_x;
   assign w_cur_y    = w_restart ? '0 : w_y;
   assign w_cur_addr = w_restart ? '0 : w_addr;

   pixel_counter #(
      .X_W (c_x_w),
      .Y_W (c_y_w),
      .A_W (c_a_w)
   ) u_pixel_counter (
      .clk_in   (clk_in),
      .reset_n  (reset_n),
      .step     (w_write),
      .restart  (w_restart),
      .eol_step (s_eol),
      .x        (w_x),
      .y        (w_y),
      .addr     (w_addr)
   );

   always_comb begin
      w_next  = r_state;
      w_write = 1'b0;
      w_err   = w_restart && (r_state == ST_ACTIVE);
      if (r_state == ST_DONE) begin
         w_next = ST_IDLE;
      end else if (w_take) begin
         // eol must coincide exactly with the last column of a line.
         if (s_eol != (w_cur_x == c_x_last)) begin
            w_err  = 1'b1;
            w_next = ST_RESYNC;
         end else begin
            w_write = 1'b1;
            w_next  = (s_eol && (w_cur_y == c_y_last)) ? ST_DONE : ST_ACTIVE;
         end
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         s_ready     <= 1'b0;
         wr_en       <= 1'b0;
         wr_address  <= '0;
         wr_data     <= '0;
         wr_bank     <= 1'b0;
         disp_bank   <= 1'b1;
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
         frame_count <= 8'd0;
      end else begin
         s_ready     <= (w_next != ST_DONE);
         wr_en       <= w_write;
         frame_error <= w_err;
         frame_done  <= (w_next == ST_DONE);
         if (w_write) begin
            wr_address <= w_cur_addr;
            wr_data    <= s_data;
         end
         // Bank swap happens as DONE ends, after the final write used the old bank.
         if (r_state == ST_DONE) begin
            disp_bank   <= wr_bank;
            wr_bank     <= ~wr_bank;
            frame_count <= frame_count + 8'd1;
         end
      end
   end

endmodule : frame_writer
`default_nettype wire

// File: tb/tb_frame_writer.sv
`default_nettype none
// =============================================================================
// Module   : tb_frame_writer
// Brief    : Scoreboard bench for frame_writer on a small 8x4 frame geometry.
// Revision : 1.0
// =============================================================================
module tb_frame_writer;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int N  = W * H;
   localparam int DS = 11;
   localparam int AS = 14;

   logic          clk_in = 1'b0;
   logic          reset_n = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DS:0]   s_data = '0;
   logic          s_sof = 1'b0;
   logic          s_eol = 1'b0;
   logic          wr_en;
   logic [AS:0]   wr_address;
   logic [DS:0]   wr_data;
   logic          wr_bank;
   logic          disp_bank;
   logic          frame_done;
   logic          frame_error;
   logic [7:0]    frame_count;

   frame_writer #(
      .image_width  (W),
      .image_height (H),
      .data_size    (DS),
      .address_size (AS)
   ) dut (
      .clk_in      (clk_in),
      .reset_n     (reset_n),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_sof       (s_sof),
      .s_eol       (s_eol),
      .wr_en       (wr_en),
      .wr_address  (wr_address),
      .wr_data     (wr_data),
      .wr_bank     (wr_bank),
      .disp_bank   (disp_bank),
      .frame_done  (frame_done),
      .frame_error (frame_error),
      .frame_count (frame_count)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   typedef struct { int cyc; int addr; logic [DS:0] data; } wr_t;
   typedef struct { int cyc; logic bank; } dn_t;
   wr_t wq[$];
   dn_t dq[$];
   int  eq[$];

   int checks = 0;
   int errors = 0;

   // Reference model: a frame is a run of N pixels indexed 0..N-1 from the sof.
   bit   in_frame = 0;
   int   p = 0;
   logic exp_bank = 1'b0;
   logic exp_disp = 1'b1;
   int   exp_count = 0;
   bit   done_pending = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_accept(input logic [DS:0] d, input bit sof, input bit eol);
      bit err = 0;
      if (sof) begin
         if (in_frame) err = 1;
         in_frame = 1;
         p = 0;
      end
      if (in_frame) begin
         if (eol != ((p % W) == W - 1)) begin
            err = 1;
            in_frame = 0;
         end else begin
            wq.push_back('{cyc + 1, p, d});
            p++;
            if (p == N) begin
               dq.push_back('{cyc + 1, exp_bank});
               exp_disp  = exp_bank;
               exp_bank  = ~exp_bank;
               exp_count = (exp_count + 1) % 256;
               in_frame  = 0;
               done_pending = 1;
            end
         end
      end
      if (err) eq.push_back(cyc + 1);
   endtask

   always @(negedge clk_in) begin : monitor
      bit  ew, ee, ed;
      wr_t w;
      dn_t d;
      if (reset_n) begin
         ew = (wq.size() > 0) && (wq[0].cyc == cyc);
         chk("wr_en", {31'd0, wr_en}, {31'd0, ew});
         if (ew) begin
            w = wq.pop_front();
            if (wr_en) begin
               chk("wr_address", {17'd0, wr_address}, w.addr);
               chk("wr_data", {20'd0, wr_data}, {20'd0, w.data});
            end
         end
         ee = (eq.size() > 0) && (eq[0] == cyc);
         chk("frame_error", {31'd0, frame_error}, {31'd0, ee});
         if (ee) void'(eq.pop_front());
         ed = (dq.size() > 0) && (dq[0].cyc == cyc);
         chk("frame_done", {31'd0, frame_done}, {31'd0, ed});
         if (ed) begin
            d = dq.pop_front();
            if (frame_done) chk("wr_bank_at_done", {31'd0, wr_bank}, {31'd0, d.bank});
         end
      end
   end

   task automatic ready_check();
      chk("s_ready", {31'd0, s_ready}, {31'd0, !done_pending});
      done_pending = 0;
   endtask

   task automatic send(input bit sof, input bit eol, input int gap);
      bit sent = 0;
      int tries = 0;
      while (!sent) begin
         @(negedge clk_in);
         ready_check();
         s_sof   = sof;
         s_eol   = eol;
         s_data  = 12'($urandom_range(4095));
         s_valid = (tries > 40) || (int'($urandom_range(99)) >= gap);
         if (s_valid && s_ready) begin
            model_accept(s_data, sof, eol);
            sent = 1;
         end else if (tries >= 100) begin
            chk("accept_timeout", 32'd0, 32'd1);
            sent = 1;
         end
         tries++;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk_in);
         ready_check();
         s_valid = 1'b0;
         s_sof   = 1'b0;
         s_eol   = 1'b0;
      end
   endtask

   task automatic send_frame(input int gap, input int count);
      for (int i = 0; i < count; i++) send(i == 0, (i % W) == W - 1, gap);
   endtask

   task automatic check_status();
      idle(3);
      chk("frame_count", {24'd0, frame_count}, exp_count);
      chk("wr_bank", {31'd0, wr_bank}, {31'd0, exp_bank});
      chk("disp_bank", {31'd0, disp_bank}, {31'd0, exp_disp});
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      s_valid  = 1'b0;
      reset_n  = 1'b0;
      in_frame = 0;
      p = 0;
      exp_bank = 1'b0;
      exp_disp = 1'b1;
      exp_count = 0;
      done_pending = 0;
      #1;
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_wr_address", {17'd0, wr_address}, 32'd0);
      chk("rst_wr_data", {20'd0, wr_data}, 32'd0);
      chk("rst_wr_bank", {31'd0, wr_bank}, 32'd0);
      chk("rst_disp_bank", {31'd0, disp_bank}, 32'd1);
      chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
      chk("rst_frame_error", {31'd0, frame_error}, 32'd0);
      chk("rst_frame_count", {24'd0, frame_count}, 32'd0);
      chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
      repeat (2) @(negedge clk_in);
      reset_n = 1'b1;
   endtask

   initial begin
      do_reset();
      idle(2);

      // Garbage before any sof must be discarded silently.
      for (int i = 0; i < 37; i++) send(0, (i % W) == W - 1, 0);
      idle(2);

      send_frame(0, N);
      check_status();

      send_frame(50, N);
      check_status();

      // Short line: eol at column 5 of line 2, then discarded pixels.
      send_frame(0, 2 * W + 5);
      send(0, 1, 0);
      for (int i = 0; i < 10; i++) send(0, ($urandom_range(1) == 1), 0);
      check_status();
      send_frame(0, N);
      check_status();

      // Early sof restarts the frame.
      send_frame(0, 13);
      send_frame(30, N);
      check_status();

      // sof together with eol is illegal for a multi-pixel line.
      send(1, 1, 0);
      idle(2);
      send_frame(0, N);
      check_status();

      while (exp_count != 0) send_frame(10, N);
      check_status();

      send_frame(0, 13);
      idle(1);
      do_reset();
      idle(2);
      send_frame(0, N);
      check_status();

      idle(3);
      chk("leftover_writes", wq.size(), 32'd0);
      chk("leftover_errors", eq.size(), 32'd0);
      chk("leftover_done", dq.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_frame_writer
`default_nettype wire

// File: doc/frame_writer.md
FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 SHALL provide parameter image_width, default 160, pixels per line.
REQ-002 SHALL provide parameter image_height, default 140, lines per frame.
REQ-003 SHALL provide parameter data_size, default 11, MSB index of the RGB444 pixel word.
REQ-004 SHALL provide parameter address_size, default 14, MSB index of the frame-buffer address.
REQ-005 clk_in  input  1  single clock; all logic on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 s_valid  input  1  upstream pixel valid.
REQ-008 s_ready  output  1  block can accept a pixel.
REQ-009 s_data  input  data_size+1  pixel {r,g,b}, 4 bits each.
REQ-010 s_sof  input  1  qualifies the first pixel of a frame.
REQ-011 s_eol  input  1  qualifies the last pixel of a line.
REQ-012 wr_en  output  1  frame-buffer write strobe.
REQ-013 wr_address  output  address_size+1  write address, y*image_width+x.
REQ-014 wr_data  output  data_size+1  write data.
REQ-015 wr_bank  output  1  bank being written.
REQ-016 disp_bank  output  1  last completed bank, for the VGA read side.
REQ-017 frame_done  output  1  one-cycle pulse on a completed frame.
REQ-018 frame_error  output  1  one-cycle pulse on a framing violation.
REQ-019 frame_count  output  8  count of completed frames, wraps 255->0.

Function
REQ-020 A pixel SHALL be accepted when s_valid and s_ready are both 1 on a clock edge.
REQ-021 s_ready SHALL be 1 in every state except DONE.
REQ-022 States SHALL be IDLE, ACTIVE, DONE and RESYNC.
REQ-023 IDLE SHALL discard accepted pixels without s_sof and SHALL move to ACTIVE on an accepted pixel with s_sof.
REQ-024 The s_sof pixel SHALL be written at address 0, with x=1, y=0.
REQ-025 In ACTIVE, each accepted pixel SHALL be written at the running address, which then increments by 1.
REQ-026 In ACTIVE, x SHALL increment by 1, and on x=image_width-1 with s_eol, x SHALL go to 0 and y SHALL increment.
REQ-027 wr_en, wr_address and wr_data SHALL be registered and SHALL appear exactly 1 cycle after acceptance.
REQ-028 wr_en SHALL be 0 when no write is due.
REQ-029 An accepted pixel at x=image_width-1, y=image_height-1 with s_eol SHALL be written and SHALL move the state to DONE.
REQ-030 DONE SHALL last one cycle and then move to IDLE.
REQ-031 The cycle in DONE SHALL pulse frame_done, set disp_bank to wr_bank, toggle wr_bank and increment frame_count.
REQ-032 An accepted s_eol at x != image_width-1 SHALL be a violation.
REQ-033 An accepted pixel at x=image_width-1 without s_eol SHALL be a violation.
REQ-034 On a violation, the pixel SHALL NOT be written, frame_error SHALL pulse 1 cycle later, the state SHALL move to RESYNC, and the bank SHALL NOT toggle.
REQ-035 An accepted s_sof in ACTIVE SHALL pulse frame_error and SHALL restart the frame: that pixel is written at address 0, x=1, y=0, and the state stays ACTIVE.
REQ-036 RESYNC SHALL discard pixels until an accepted s_sof, which SHALL be handled as in IDLE.
REQ-037 A pixel with both s_sof and s_eol SHALL be handled first as s_sof, then checked for s_eol against x=0.
REQ-038 When image_width=1, the s_sof and s_eol pixel of REQ-037 SHALL be legal.
REQ-039 When the product image_width*image_height exceeds 2^(address_size+1), elaboration SHALL fail.
REQ-040 s_valid low SHALL hold all counters and the state, with no timeout.

Reset
REQ-041 reset_n low SHALL asynchronously force: state IDLE; x, y and address 0; wr_en 0; wr_address 0; wr_data 0.
REQ-042 reset_n low SHALL also force: wr_bank 0, disp_bank 1, frame_done 0, frame_error 0, frame_count 0, s_ready 0.
REQ-043 s_ready SHALL go to 1 on the first clock edge after reset_n deasserts.
REQ-044 A reset mid-frame SHALL drop the partial frame, with no frame_done and no frame_error.

Structure
REQ-045 A shared package SHALL hold image_width, image_height, data_size, address_size and the state encoding, for use by the read-side VGA logic.
REQ-046 The x/y/address counter SHALL be one sub-module, pixel_counter, with inputs step, restart and eol_step and outputs x, y and addr.
REQ-047 The state machine and output registers SHALL stay in frame_writer.

Verification
REQ-048 Clean frame: 160x140 pixels, sof on the first, eol every 160th -> 22400 writes at addresses 0..22399 in order; one frame_done; wr_bank 0->1; disp_bank=0; frame_count=1.
REQ-049 Short line: eol at x=99 of line 5 -> no write for that pixel; frame_error pulses; RESYNC; no writes until the next sof; frame_count unchanged.
REQ-050 Early sof: sof at pixel 500 of a frame -> frame_error pulses; that pixel is written at address 0; the following full frame completes with frame_done.
REQ-051 Gapped valid: random s_valid low 50% over a full frame -> same address/data sequence as REQ-048; every write exactly 1 cycle after its accept.
REQ-052 Pre-sof garbage: 37 pixels without sof in IDLE -> wr_en stays 0.
REQ-053 Wrap and reset: 256 clean frames -> frame_count wraps to 0 and wr_bank ends at 0. Then reset_n low at pixel 1000 of a frame -> all outputs at reset values, and the next frame writes from address 0.
